control_fsm_mc: RTL and testbench
=================================

// Module: control_fsm_mc
// PURPOSE
//   Parametrised multicycle control unit for the RV64 datapath ("processing").
//   Decodes the instruction, sequences fetch/decode/execute/memory/writeback
//   and drives every datapath control flag.
//   New over the previous control FSM:
//   - configurable instruction- and data-memory wait states;
//   - overflow traps;
//   - vectored exception entry that resumes fetching;
//   - sticky halt on ebreak.
// PARAMETERS
//   IMEM_LAT  0  extra cycles the instruction memory needs before IR data is valid (0..15)
//   DMEM_LAT  1  extra cycles the data memory needs per load/store access (0..15)
//   OVF_TRAP  1  1: signed overflow on add/sub/addi raises exception cause 1; 0: ignored
// PORTS
//   clk            in   1   clock
//   reset          in   1   asynchronous, active-high reset
//   instruction    in   32  IR contents from datapath
//   alu_equal      in   1   ALU compare: A == B
//   alu_greater    in   1   ALU compare: A >= B (signed)
//   alu_less       in   1   ALU compare: A < B (signed)
//   alu_overflow   in   1   signed overflow of current ALU operation
//   PCWrite,PCWriteCond,PCWriteState  out 1  PC write enables; PCWriteState = PCWrite | (PCWriteCond & branch_cond)
//   PCSource       out  2   00 ALU result, 01 ALUOut reg, 10 exception vector
//   ALUSrcA,ALUSrcB out 2   ALU operand selects (operations:: encodings)
//   ALUOp          out  4   ALU operation (operations:: encodings)
//   LoadAOut,LoadRegA,LoadRegB,RegWrite,IRWrite,IMemRead,LoadMDR,DMemOp  out 1  datapath strobes
//   MemToReg       out  2   writeback source
//   LoadSplice,StoreSplice  out 2  load/store width select
//   DataMemSrc,IntCause,CauseWrite,EPCWrite  out 1  exception datapath controls
//   halted         out  1   sticky after ebreak
//   state_dbg      out  5   current state encoding (debug)
// BEHAVIOUR
//   Outputs
//   - Moore outputs are decoded from state and wait counter only.
//   - Defaults: all 0; ALUOp = SUM.
//   - Reset (async) forces state = START, wait_cnt = 0 and halted = 0.
//     All outputs then take their defaults immediately.
//     Reset mid-access drops any in-flight strobe at once.
//   Wait counter wait_cnt[3:0]
//   - Cleared on entry to FETCH, LD_REQ and ST.
//   - Increments while below the applicable LAT.
//   Fetch and decode
//   - START -> FETCH.
//   - FETCH: IMemRead = 1 while wait_cnt < IMEM_LAT.
//     When wait_cnt == IMEM_LAT, additionally assert IRWrite and PCWrite with
//     PC+4 (ALUSrcA = PC, ALUSrcB = CONST4, PCSource = 00), then -> DECODE.
//     IMEM_LAT = 0 gives a single-cycle fetch.
//   - DECODE: LoadRegA, LoadRegB and LoadAOut assert; ALU computes PC+imm2. Next state by opcode:
//     LD/S -> MEM_ADDR; IMM_ARITH -> EXEC_I; R -> EXEC_R; U -> EXEC_U;
//     SB -> BRANCH; JAL/JALR -> LINK; BREAK -> HALT if ebreak (instr[20] = 1, all
//     other bits [31:7] zero), else EXC_CAUSE with IntCause = 0; any other opcode -> EXC_CAUSE with IntCause = 0.
//   Memory
//   - MEM_ADDR: ALU computes A+imm and LoadAOut asserts. LD -> LD_REQ; S -> ST.
//   - LD_REQ: DMemOp = 0 for DMEM_LAT+1 cycles. LoadMDR asserts in the last cycle, then -> WB_LD.
//   - WB_LD: RegWrite = 1, MemToReg = 01, LoadSplice selected by funct3; -> FETCH.
//   - ST: DMemOp = 1 and StoreSplice selected by funct3, held for DMEM_LAT+1 cycles; -> FETCH.
//   ALU instructions
//   - EXEC_R, EXEC_I, EXEC_U: ALU op selected by funct3/funct7 (SRAI/SRLI split on funct6); LoadAOut = 1.
//   - If OVF_TRAP = 1, alu_overflow = 1 and the op is add, sub or addi:
//     -> EXC_CAUSE with IntCause = 1; no writeback.
//   - Otherwise -> ALU_WB: RegWrite = 1, MemToReg = ALU_OUT; -> FETCH.
//   Branches and jumps
//   - BRANCH: PCWriteCond = 1, PCSource = 01, compares A with B.
//     branch_cond covers BEQ, BNE, BGE, BLT; any other funct3 is not taken.
//     -> REDIRECT.
//   - LINK: RegWrite = 1, MemToReg = PC_4. -> JAL_PC or JALR_PC.
//   - JAL_PC: PCWrite, PCSource = 00.
//   - JALR_PC: PCWrite, PCSource = 01.
//     Both -> REDIRECT.
//   - REDIRECT: one idle cycle for IMEM address settle; -> FETCH.
//   Exceptions and halt
//   - EXC_CAUSE: CauseWrite = 1, EPCWrite = 1, DataMemSrc = 1, IntCause held; -> EXC_VEC.
//   - EXC_VEC: PCWrite = 1, PCSource = 10; -> FETCH, so the handler executes.
//   - HALT: halted = 1, all strobes 0. Stays until reset.
//   Unused state encodings -> FETCH.
// TESTING
//   1 IMEM_LAT=2: reset then release -> IMemRead for 3 cycles; IRWrite and PCWrite only in the 3rd; PC 0->4.
//   2 DMEM_LAT=3, ld x5,8(x1) with x1=0x100 -> LoadMDR exactly 4 cycles after LD_REQ entry; x5 = mem[0x108].
//   3 beq taken (x1=x2=7, imm 16, PC 0x20) -> PC = 0x30. bne same operands -> PC = 0x24.
//   4 add x3 = 0x7FFF_FFFF_FFFF_FFFF + 1 with OVF_TRAP=1 -> CauseWrite, IntCause=1, no RegWrite, PC=vector.
//     With OVF_TRAP=0 -> x3 = 0x8000_0000_0000_0000.
//   5 Opcode 0x7F -> IntCause=0, EPCWrite. Then 0x00100073 (ebreak) -> halted=1 and held 100 cycles.
//   6 Assert reset during ST wait -> DMemOp drops same cycle; after release, state START -> FETCH.

Source files
------------

// File: rtl/control_fsm_mc_if.sv
// rtl/control_fsm_mc_if.sv - control unit <-> datapath signal bundle
interface control_fsm_mc_if;
    logic [31:0] instruction;
    logic        alu_equal;
    logic        alu_greater;
    logic        alu_less;
    logic        alu_overflow;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        PCWriteState;
    logic [1:0]  PCSource;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [3:0]  ALUOp;
    logic        LoadAOut;
    logic        LoadRegA;
    logic        LoadRegB;
    logic        RegWrite;
    logic        IRWrite;
    logic        IMemRead;
    logic        LoadMDR;
    logic        DMemOp;
    logic [1:0]  MemToReg;
    logic [1:0]  LoadSplice;
    logic [1:0]  StoreSplice;
    logic        DataMemSrc;
    logic        IntCause;
    logic        CauseWrite;
    logic        EPCWrite;
    logic        halted;
    logic [4:0]  state_dbg;

    modport master (
        input  instruction, alu_equal, alu_greater, alu_less, alu_overflow,
        output PCWrite, PCWriteCond, PCWriteState, PCSource, ALUSrcA, ALUSrcB, ALUOp,
               LoadAOut, LoadRegA, LoadRegB, RegWrite, IRWrite, IMemRead, LoadMDR, DMemOp,
               MemToReg, LoadSplice, StoreSplice, DataMemSrc, IntCause, CauseWrite, EPCWrite,
               halted, state_dbg
    );

    modport slave (
        output instruction, alu_equal, alu_greater, alu_less, alu_overflow,
        input  PCWrite, PCWriteCond, PCWriteState, PCSource, ALUSrcA, ALUSrcB, ALUOp,
               LoadAOut, LoadRegA, LoadRegB, RegWrite, IRWrite, IMemRead, LoadMDR, DMemOp,
               MemToReg, LoadSplice, StoreSplice, DataMemSrc, IntCause, CauseWrite, EPCWrite,
               halted, state_dbg
    );
endinterface

// File: rtl/control_fsm_mc.sv
// rtl/control_fsm_mc.sv - multicycle RV64 control FSM with memory wait states, overflow traps and halt
module control_fsm_mc #(
    parameter int IMEM_LAT = 0,
    parameter int DMEM_LAT = 1,
    parameter int OVF_TRAP = 1
) (
    input  logic              clk,
    input  logic              reset,
    control_fsm_mc_if.master  ctrl
);
    localparam logic [3:0] IMEM_LAT_C = 4'(IMEM_LAT);
    localparam logic [3:0] DMEM_LAT_C = 4'(DMEM_LAT);

    localparam logic [3:0] ALU_SUM = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_PASSB = 4'd10;
    localparam logic [1:0] SRCA_PC = 2'b00, SRCA_REG = 2'b01;
    localparam logic [1:0] SRCB_REG = 2'b00, SRCB_4 = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM2 = 2'b11;
    localparam logic [6:0] OP_LD = 7'b0000011, OP_S = 7'b0100011, OP_IMM = 7'b0010011,
                           OP_R = 7'b0110011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                           OP_SB = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                           OP_SYS = 7'b1110011;

    typedef enum logic [4:0] {
        S_START = 5'd0, S_FETCH = 5'd1, S_DECODE = 5'd2, S_MEM_ADDR = 5'd3, S_LD_REQ = 5'd4,
        S_WB_LD = 5'd5, S_ST = 5'd6, S_EXEC_R = 5'd7, S_EXEC_I = 5'd8, S_EXEC_U = 5'd9,
        S_ALU_WB = 5'd10, S_BRANCH = 5'd11, S_LINK = 5'd12, S_JAL_PC = 5'd13, S_JALR_PC = 5'd14,
        S_REDIRECT = 5'd15, S_EXC_CAUSE = 5'd16, S_EXC_VEC = 5'd17, S_HALT = 5'd18
    } state_t;

    state_t      r_state, w_state_next;
    logic [3:0]  r_wait_cnt, w_wait_next;
    logic        r_halted, r_int_cause, w_int_cause_next;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_is_ebreak, w_branch_cond, w_ovf_op, w_trap;
    logic [3:0]  w_alu_r, w_alu_i;

    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_sel = alt ? ALU_SUB : ALU_SUM;
            3'b001:  alu_sel = ALU_SLL;
            3'b010:  alu_sel = ALU_SLT;
            3'b011:  alu_sel = ALU_SLTU;
            3'b100:  alu_sel = ALU_XOR;
            3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_sel = ALU_OR;
            default: alu_sel = ALU_AND;
        endcase
    endfunction

    assign w_opcode    = ctrl.instruction[6:0];
    assign w_funct3    = ctrl.instruction[14:12];
    assign w_is_ebreak = (ctrl.instruction[31:7] == 25'h0002000);
    // Immediate shifts carry shamt[5] in bit 25, so SRAI is recognised on funct6 alone
    assign w_alu_r     = alu_sel(w_funct3, ctrl.instruction[30]);
    assign w_alu_i     = alu_sel(w_funct3, (w_funct3 == 3'b101) && (ctrl.instruction[31:26] == 6'b010000));
    assign w_ovf_op    = (w_funct3 == 3'b000) &&
                         ((r_state == S_EXEC_I) ||
                          ((r_state == S_EXEC_R) && ((ctrl.instruction[31:25] == 7'b0000000) ||
                                                     (ctrl.instruction[31:25] == 7'b0100000))));
    assign w_trap      = (OVF_TRAP != 0) && ctrl.alu_overflow && w_ovf_op;

    always_comb begin
        case (w_funct3)
            3'b000:  w_branch_cond = ctrl.alu_equal;
            3'b001:  w_branch_cond = ~ctrl.alu_equal;
            3'b100:  w_branch_cond = ctrl.alu_less;
            3'b101:  w_branch_cond = ctrl.alu_greater;
            default: w_branch_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_START;
            r_wait_cnt  <= 4'd0;
            r_halted    <= 1'b0;
            r_int_cause <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_wait_cnt  <= w_wait_next;
            r_halted    <= r_halted | (w_state_next == S_HALT);
            r_int_cause <= w_int_cause_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_int_cause_next   = r_int_cause;
        ctrl.PCWrite       = 1'b0;
        ctrl.PCWriteCond   = 1'b0;
        ctrl.PCSource      = 2'b00;
        ctrl.ALUSrcA       = SRCA_PC;
        ctrl.ALUSrcB       = SRCB_REG;
        ctrl.ALUOp         = ALU_SUM;
        ctrl.LoadAOut      = 1'b0;
        ctrl.LoadRegA      = 1'b0;
        ctrl.LoadRegB      = 1'b0;
        ctrl.RegWrite      = 1'b0;
        ctrl.IRWrite       = 1'b0;
        ctrl.IMemRead      = 1'b0;
        ctrl.LoadMDR       = 1'b0;
        ctrl.DMemOp        = 1'b0;
        ctrl.MemToReg      = 2'b00;
        ctrl.LoadSplice    = 2'b00;
        ctrl.StoreSplice   = 2'b00;
        ctrl.DataMemSrc    = 1'b0;
        ctrl.IntCause      = 1'b0;
        ctrl.CauseWrite    = 1'b0;
        ctrl.EPCWrite      = 1'b0;
        case (r_state)
            S_START: w_state_next = S_FETCH;
            S_FETCH: begin
                ctrl.IMemRead = 1'b1;
                if (r_wait_cnt == IMEM_LAT_C) begin
                    ctrl.IRWrite = 1'b1;
                    ctrl.PCWrite = 1'b1;
                    ctrl.ALUSrcB = SRCB_4;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ctrl.LoadRegA = 1'b1;
                ctrl.LoadRegB = 1'b1;
                ctrl.LoadAOut = 1'b1;
                ctrl.ALUSrcB  = SRCB_IMM2;
                w_state_next  = S_EXC_CAUSE;
                case (w_opcode)
                    OP_LD, OP_S:       w_state_next = S_MEM_ADDR;
                    OP_IMM:            w_state_next = S_EXEC_I;
                    OP_R:              w_state_next = S_EXEC_R;
                    OP_LUI, OP_AUIPC:  w_state_next = S_EXEC_U;
                    OP_SB:             w_state_next = S_BRANCH;
                    OP_JAL, OP_JALR:   w_state_next = S_LINK;
                    OP_SYS:            if (w_is_ebreak) w_state_next = S_HALT;
                    default:           w_state_next = S_EXC_CAUSE;
                endcase
                if (w_state_next == S_EXC_CAUSE) w_int_cause_next = 1'b0;
            end
            S_MEM_ADDR: begin
                ctrl.ALUSrcA = SRCA_REG;
                ctrl.ALUSrcB = SRCB_IMM;
                ctrl.LoadAOut = 1'b1;
                w_state_next = (w_opcode == OP_LD) ? S_LD_REQ : S_ST;
            end
            S_LD_REQ: begin
                if (r_wait_cnt == DMEM_LAT_C) begin
                    ctrl.LoadMDR = 1'b1;
                    w_state_next = S_WB_LD;
                end
            end
            S_WB_LD: begin
                ctrl.RegWrite   = 1'b1;
                ctrl.MemToReg   = 2'b01;
                ctrl.LoadSplice = w_funct3[1:0];
                w_state_next    = S_FETCH;
            end
            S_ST: begin
                ctrl.DMemOp      = 1'b1;
                ctrl.StoreSplice = w_funct3[1:0];
                if (r_wait_cnt == DMEM_LAT_C) w_state_next = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                ctrl.ALUSrcA  = SRCA_REG;
                ctrl.ALUSrcB  = (r_state == S_EXEC_R) ? SRCB_REG : SRCB_IMM;
                ctrl.ALUOp    = (r_state == S_EXEC_R) ? w_alu_r : w_alu_i;
                ctrl.LoadAOut = 1'b1;
                if (w_trap) begin
                    w_state_next     = S_EXC_CAUSE;
                    w_int_cause_next = 1'b1;
                end else begin
                    w_state_next = S_ALU_WB;
                end
            end
            S_EXEC_U: begin
                ctrl.ALUSrcA  = SRCA_PC;
                ctrl.ALUSrcB  = SRCB_IMM;
                ctrl.ALUOp    = (w_opcode == OP_LUI) ? ALU_PASSB : ALU_SUM;
                ctrl.LoadAOut = 1'b1;
                w_state_next  = S_ALU_WB;
            end
            S_ALU_WB: begin
                ctrl.RegWrite = 1'b1;
                w_state_next  = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.PCWriteCond = 1'b1;
                ctrl.PCSource    = 2'b01;
                ctrl.ALUSrcA     = SRCA_REG;
                ctrl.ALUOp       = ALU_SUB;
                w_state_next     = S_REDIRECT;
            end
            S_LINK: begin
                ctrl.RegWrite = 1'b1;
                ctrl.MemToReg = 2'b10;
                ctrl.ALUSrcA  = SRCA_REG;
                ctrl.ALUSrcB  = SRCB_IMM;
                ctrl.LoadAOut = 1'b1;
                w_state_next  = (w_opcode == OP_JALR) ? S_JALR_PC : S_JAL_PC;
            end
            S_JAL_PC: begin
                ctrl.PCWrite = 1'b1;
                ctrl.ALUSrcB = SRCB_IMM;
                w_state_next = S_REDIRECT;
            end
            S_JALR_PC: begin
                ctrl.PCWrite  = 1'b1;
                ctrl.PCSource = 2'b01;
                w_state_next  = S_REDIRECT;
            end
            S_REDIRECT: w_state_next = S_FETCH;
            S_EXC_CAUSE: begin
                ctrl.CauseWrite = 1'b1;
                ctrl.EPCWrite   = 1'b1;
                ctrl.DataMemSrc = 1'b1;
                ctrl.IntCause   = r_int_cause;
                w_state_next    = S_EXC_VEC;
            end
            S_EXC_VEC: begin
                ctrl.PCWrite  = 1'b1;
                ctrl.PCSource = 2'b10;
                w_state_next  = S_FETCH;
            end
            S_HALT:  w_state_next = S_HALT;
            default: w_state_next = S_FETCH;
        endcase
    end

    // Counter restarts on every state change so each wait window begins at zero
    always_comb begin
        w_wait_next = r_wait_cnt;
        if (w_state_next != r_state)
            w_wait_next = 4'd0;
        else if ((r_state == S_FETCH) && (r_wait_cnt < IMEM_LAT_C))
            w_wait_next = r_wait_cnt + 4'd1;
        else if (((r_state == S_LD_REQ) || (r_state == S_ST)) && (r_wait_cnt < DMEM_LAT_C))
            w_wait_next = r_wait_cnt + 4'd1;
    end

    assign ctrl.PCWriteState = ctrl.PCWrite | (ctrl.PCWriteCond & w_branch_cond);
    assign ctrl.halted       = r_halted;
    assign ctrl.state_dbg    = r_state;
endmodule

// File: tb/tb_control_fsm_mc.sv
// tb/tb_control_fsm_mc.sv - directed bench for control_fsm_mc (slow-memory trap unit and default unit)
module tb_control_fsm_mc;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    control_fsm_mc_if bus1();
    control_fsm_mc_if bus2();

    assign bus2.instruction  = bus1.instruction;
    assign bus2.alu_equal    = bus1.alu_equal;
    assign bus2.alu_greater  = bus1.alu_greater;
    assign bus2.alu_less     = bus1.alu_less;
    assign bus2.alu_overflow = bus1.alu_overflow;

    control_fsm_mc #(.IMEM_LAT(2), .DMEM_LAT(3), .OVF_TRAP(1)) dut1 (.clk(clk), .reset(reset), .ctrl(bus1));
    control_fsm_mc #(.IMEM_LAT(0), .DMEM_LAT(1), .OVF_TRAP(0)) dut2 (.clk(clk), .reset(reset), .ctrl(bus2));

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input logic [31:0] instr, input logic ovf);
        bus1.instruction  = instr;
        bus1.alu_equal    = 1'b0;
        bus1.alu_greater  = 1'b0;
        bus1.alu_less     = 1'b0;
        bus1.alu_overflow = ovf;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        bus1.instruction = 32'h0000_0013;
        bus1.alu_equal = 0; bus1.alu_greater = 0; bus1.alu_less = 0; bus1.alu_overflow = 0;
        reset = 1'b1;
        #1;
        checks++; if (bus1.state_dbg !== 5'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", bus1.state_dbg); end
        checks++; if (bus1.IMemRead !== 1'b0 || bus1.PCWrite !== 1'b0 || bus1.RegWrite !== 1'b0) begin errors++; $display("FAIL reset_strobes got=%b%b%b exp=000", bus1.IMemRead, bus1.PCWrite, bus1.RegWrite); end
        checks++; if (bus1.ALUOp !== 4'd0 || bus1.halted !== 1'b0) begin errors++; $display("FAIL reset_aluop_halted got=%0d/%b exp=0/0", bus1.ALUOp, bus1.halted); end
        checks++; if (bus2.state_dbg !== 5'd0) begin errors++; $display("FAIL reset_state2 got=%0d exp=0", bus2.state_dbg); end
        tick(1);
    endtask

    task automatic test_fetch;
        start(32'h0000_0013, 1'b0);
        for (int p = 1; p <= 3; p++) begin
            tick(1);
            checks++; if (bus1.state_dbg !== 5'd1 || bus1.IMemRead !== 1'b1) begin errors++; $display("FAIL fetch_imemread p%0d got=%0d/%b exp=1/1", p, bus1.state_dbg, bus1.IMemRead); end
            checks++; if (bus1.IRWrite !== (p == 3) || bus1.PCWrite !== (p == 3)) begin errors++; $display("FAIL fetch_irwrite p%0d got=%b%b exp=%b", p, bus1.IRWrite, bus1.PCWrite, (p == 3)); end
            if (p == 1) begin
                checks++; if (bus2.IRWrite !== 1'b1 || bus2.PCWrite !== 1'b1) begin errors++; $display("FAIL fetch_zero_lat got=%b%b exp=11", bus2.IRWrite, bus2.PCWrite); end
            end
            if (p == 3) begin
                checks++; if (bus1.ALUSrcA !== 2'b00 || bus1.ALUSrcB !== 2'b01 || bus1.PCSource !== 2'b00) begin errors++; $display("FAIL fetch_pc4 got=%b/%b/%b exp=00/01/00", bus1.ALUSrcA, bus1.ALUSrcB, bus1.PCSource); end
            end
        end
        tick(1);
        checks++; if (bus1.state_dbg !== 5'd2 || bus1.IMemRead !== 1'b0 || bus1.LoadRegA !== 1'b1) begin errors++; $display("FAIL decode_entry got=%0d/%b/%b exp=2/0/1", bus1.state_dbg, bus1.IMemRead, bus1.LoadRegA); end
    endtask

    task automatic test_load;
        start(32'h0080_B283, 1'b0);
        tick(5);
        checks++; if (bus1.state_dbg !== 5'd3 || bus1.ALUSrcB !== 2'b10 || bus1.LoadAOut !== 1'b1) begin errors++; $display("FAIL ld_memaddr got=%0d/%b/%b exp=3/10/1", bus1.state_dbg, bus1.ALUSrcB, bus1.LoadAOut); end
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checks++; if (bus1.state_dbg !== 5'd4 || bus1.LoadMDR !== (i == 3) || bus1.DMemOp !== 1'b0) begin errors++; $display("FAIL ld_req c%0d got=%0d/%b exp=4/%b", i, bus1.state_dbg, bus1.LoadMDR, (i == 3)); end
        end
        tick(1);
        checks++; if (bus1.state_dbg !== 5'd5 || bus1.RegWrite !== 1'b1 || bus1.MemToReg !== 2'b01 || bus1.LoadSplice !== 2'b11) begin errors++; $display("FAIL ld_wb got=%0d/%b/%b/%b exp=5/1/01/11", bus1.state_dbg, bus1.RegWrite, bus1.MemToReg, bus1.LoadSplice); end
        tick(1);
        checks++; if (bus1.state_dbg !== 5'd1) begin errors++; $display("FAIL ld_refetch got=%0d exp=1", bus1.state_dbg); end
    endtask

    task automatic test_store;
        start(32'h0020_B023, 1'b0);
        tick(5);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checks++; if (bus1.state_dbg !== 5'd6 || bus1.DMemOp !== 1'b1 || bus1.StoreSplice !== 2'b11) begin errors++; $display("FAIL st_hold c%0d got=%0d/%b/%b exp=6/1/11", i, bus1.state_dbg, bus1.DMemOp, bus1.StoreSplice); end
        end
        tick(1);
        checks++; if (bus1.state_dbg !== 5'd1 || bus1.DMemOp !== 1'b0) begin errors++; $display("FAIL st_done got=%0d/%b exp=1/0", bus1.state_dbg, bus1.DMemOp); end
    endtask

    task automatic test_reset_mid_store;
        start(32'h0020_B023, 1'b0);
        tick(7);
        checks++; if (bus1.DMemOp !== 1'b1) begin errors++; $display("FAIL rst_st_pre got=%b exp=1", bus1.DMemOp); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus1.DMemOp !== 1'b0 || bus1.state_dbg !== 5'd0) begin errors++; $display("FAIL rst_st_drop got=%b/%0d exp=0/0", bus1.DMemOp, bus1.state_dbg); end
        reset = 1'b0;
        tick(1);
        checks++; if (bus1.state_dbg !== 5'd1) begin errors++; $display("FAIL rst_st_refetch got=%0d exp=1", bus1.state_dbg); end
    endtask

    task automatic test_branch;
        logic [2:0] f3  [7] = '{3'b000, 3'b001, 3'b001, 3'b101, 3'b100, 3'b100, 3'b010};
        logic       eq  [7] = '{1'b1,   1'b1,   1'b0,   1'b0,   1'b0,   1'b0,   1'b1};
        logic       gt  [7] = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b0,   1'b0,   1'b1};
        logic       lt  [7] = '{1'b0,   1'b0,   1'b1,   1'b0,   1'b0,   1'b1,   1'b0};
        logic       exp [7] = '{1'b1,   1'b0,   1'b1,   1'b1,   1'b0,   1'b1,   1'b0};
        for (int k = 0; k < 7; k++) begin
            start(32'h0020_8863 | (32'(f3[k]) << 12), 1'b0);
            tick(4);
            bus1.alu_equal = eq[k]; bus1.alu_greater = gt[k]; bus1.alu_less = lt[k];
            tick(1);
            checks++; if (bus1.state_dbg !== 5'd11 || bus1.PCWriteState !== exp[k] || bus1.PCWriteCond !== 1'b1 || bus1.PCSource !== 2'b01) begin errors++; $display("FAIL branch%0d got=%0d/%b/%b/%b exp=11/%b/1/01", k, bus1.state_dbg, bus1.PCWriteState, bus1.PCWriteCond, bus1.PCSource, exp[k]); end
            tick(1);
            checks++; if (bus1.state_dbg !== 5'd15 || bus1.PCWriteState !== 1'b0) begin errors++; $display("FAIL redirect%0d got=%0d/%b exp=15/0", k, bus1.state_dbg, bus1.PCWriteState); end
        end
        tick(1);
        checks++; if (bus1.state_dbg !== 5'd1) begin errors++; $display("FAIL branch_refetch got=%0d exp=1", bus1.state_dbg); end
    endtask

    task automatic test_overflow;
        start(32'h0020_81B3, 1'b1);
        tick(4);
        checks++; if (bus2.state_dbg !== 5'd10 || bus2.RegWrite !== 1'b1 || bus2.MemToReg !== 2'b00) begin errors++; $display("FAIL ovf_off_wb got=%0d/%b/%b exp=10/1/00", bus2.state_dbg, bus2.RegWrite, bus2.MemToReg); end
        tick(1);
        checks++; if (bus1.state_dbg !== 5'd7 || bus1.ALUOp !== 4'd0 || bus1.LoadAOut !== 1'b1) begin errors++; $display("FAIL add_exec got=%0d/%0d/%b exp=7/0/1", bus1.state_dbg, bus1.ALUOp, bus1.LoadAOut); end
        tick(1);
        checks++; if (bus1.state_dbg !== 5'd16 || bus1.CauseWrite !== 1'b1 || bus1.IntCause !== 1'b1 || bus1.EPCWrite !== 1'b1 || bus1.RegWrite !== 1'b0 || bus1.DataMemSrc !== 1'b1) begin errors++; $display("FAIL ovf_cause got=%0d/%b/%b/%b/%b exp=16/1/1/1/0", bus1.state_dbg, bus1.CauseWrite, bus1.IntCause, bus1.EPCWrite, bus1.RegWrite); end
        tick(1);
        checks++; if (bus1.state_dbg !== 5'd17 || bus1.PCWrite !== 1'b1 || bus1.PCSource !== 2'b10 || bus1.RegWrite !== 1'b0) begin errors++; $display("FAIL ovf_vector got=%0d/%b/%b exp=17/1/10", bus1.state_dbg, bus1.PCWrite, bus1.PCSource); end
        tick(1);
        checks++; if (bus1.state_dbg !== 5'd1) begin errors++; $display("FAIL ovf_resume got=%0d exp=1", bus1.state_dbg); end
        start(32'h4020_81B3, 1'b1);
        tick(5);
        checks++; if (bus1.ALUOp !== 4'd1) begin errors++; $display("FAIL sub_aluop got=%0d exp=1", bus1.ALUOp); end
        tick(1);
        checks++; if (bus1.state_dbg !== 5'd16) begin errors++; $display("FAIL sub_trap got=%0d exp=16", bus1.state_dbg); end
        start(32'h0010_8093, 1'b1);
        tick(6);
        checks++; if (bus1.state_dbg !== 5'd16 || bus1.IntCause !== 1'b1) begin errors++; $display("FAIL addi_trap got=%0d/%b exp=16/1", bus1.state_dbg, bus1.IntCause); end
        start(32'h0020_C1B3, 1'b1);
        tick(5);
        checks++; if (bus1.ALUOp !== 4'd4) begin errors++; $display("FAIL xor_aluop got=%0d exp=4", bus1.ALUOp); end
        tick(1);
        checks++; if (bus1.state_dbg !== 5'd10 || bus1.RegWrite !== 1'b1) begin errors++; $display("FAIL xor_no_trap got=%0d/%b exp=10/1", bus1.state_dbg, bus1.RegWrite); end
    endtask

    task automatic test_exception_halt;
        int bad;
        start(32'h0000_0073, 1'b0);
        tick(5);
        checks++; if (bus1.state_dbg !== 5'd16 || bus1.halted !== 1'b0) begin errors++; $display("FAIL ecall_exc got=%0d/%b exp=16/0", bus1.state_dbg, bus1.halted); end
        start(32'h0000_007F, 1'b0);
        tick(5);
        checks++; if (bus1.state_dbg !== 5'd16 || bus1.IntCause !== 1'b0 || bus1.EPCWrite !== 1'b1 || bus1.CauseWrite !== 1'b1) begin errors++; $display("FAIL illegal_cause got=%0d/%b/%b/%b exp=16/0/1/1", bus1.state_dbg, bus1.IntCause, bus1.EPCWrite, bus1.CauseWrite); end
        tick(2);
        checks++; if (bus1.state_dbg !== 5'd1 || bus1.IMemRead !== 1'b1) begin errors++; $display("FAIL illegal_resume got=%0d/%b exp=1/1", bus1.state_dbg, bus1.IMemRead); end
        bus1.instruction = 32'h0010_0073;
        tick(4);
        checks++; if (bus1.state_dbg !== 5'd18 || bus1.halted !== 1'b1) begin errors++; $display("FAIL ebreak_halt got=%0d/%b exp=18/1", bus1.state_dbg, bus1.halted); end
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            tick(1);
            if (bus1.halted !== 1'b1 || bus1.state_dbg !== 5'd18 || bus1.IMemRead !== 1'b0 || bus1.PCWrite !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL halt_sticky got=%0d bad cycles exp=0", bad); end
        start(32'h0000_0013, 1'b0);
        checks++; if (bus1.halted !== 1'b0 || bus1.state_dbg !== 5'd0) begin errors++; $display("FAIL halt_reset got=%b/%0d exp=0/0", bus1.halted, bus1.state_dbg); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] instr [2] = '{32'h0000_006F, 32'h0000_8067};
        logic [1:0]  src   [2] = '{2'b00, 2'b01};
        logic [4:0]  pcst  [2] = '{5'd13, 5'd14};
        for (int k = 0; k < 2; k++) begin
            start(instr[k], 1'b0);
            tick(3);
            checks++; if (bus2.state_dbg !== 5'd12 || bus2.RegWrite !== 1'b1 || bus2.MemToReg !== 2'b10) begin errors++; $display("FAIL link%0d got=%0d/%b/%b exp=12/1/10", k, bus2.state_dbg, bus2.RegWrite, bus2.MemToReg); end
            tick(1);
            checks++; if (bus2.state_dbg !== pcst[k] || bus2.PCWrite !== 1'b1 || bus2.PCSource !== src[k]) begin errors++; $display("FAIL jump_pc%0d got=%0d/%b/%b exp=%0d/1/%b", k, bus2.state_dbg, bus2.PCWrite, bus2.PCSource, pcst[k], src[k]); end
            tick(2);
            checks++; if (bus2.state_dbg !== 5'd1 || bus2.IRWrite !== 1'b1) begin errors++; $display("FAIL jump_refetch%0d got=%0d/%b exp=1/1", k, bus2.state_dbg, bus2.IRWrite); end
        end
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_load;
        test_store;
        test_reset_mid_store;
        test_branch;
        test_overflow;
        test_exception_halt;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
